// File: rtl/vpu_pkg.sv
// Shared VPU constants and the destination-port state type.
// Pure declarations; no timing or flow-control behaviour.
package vpu_pkg;

  localparam int OPERAND_WIDTH  = 16;
  localparam int DST_LANES      = 4;
  localparam int DST_FIFO_DEPTH = 4;
  localparam int DST_ADDR_W     = 8;

  typedef enum logic [1:0] {
    DST_IDLE    = 2'd0,
    DST_COLLECT = 2'd1,
    DST_DRAIN   = 2'd2
  } dst_state_t;

endpackage

// File: rtl/vpu_sync_fifo.sv
// Generic first-word-fall-through FIFO; a pushed entry is visible the cycle after the push.
// Pop only when pop_vld; a push while full is dropped (flagged on drop) unless a pop frees a slot.
module vpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       pop_vld,
  output logic                       full,
  output logic                       drop,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign pop_vld = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && pop_vld;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vpu_dst_port.sv
// Packs FP results into lane words and buffers them for the register-file write port.
// Words appear one cycle after completion; wr_ready_i backpressures the buffer, never the FP unit.
module vpu_dst_port #(
  parameter int OPERAND_WIDTH = vpu_pkg::OPERAND_WIDTH,
  parameter int LANES         = vpu_pkg::DST_LANES,
  parameter int FIFO_DEPTH    = vpu_pkg::DST_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [7:0]                 vlen_i,
  input  logic [7:0]                 base_addr_i,
  input  logic [OPERAND_WIDTH-1:0]   result_i,
  input  logic                       done_i,
  output logic                       wr_valid_o,
  input  logic                       wr_ready_i,
  output logic [7:0]                 wr_addr_o,
  output logic [LANES*OPERAND_WIDTH-1:0] wr_data_o,
  output logic [LANES-1:0]           wr_mask_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  import vpu_pkg::*;

  localparam int DW = LANES * OPERAND_WIDTH;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FW = 8 + LANES + DW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dst_state_t      state_q, state_d;
  logic [7:0]      vlen_q;
  logic [7:0]      base_q;
  logic [7:0]      elem_q;
  logic [7:0]      word_q;
  logic [LW-1:0]   lane_q;
  logic [DW-1:0]   acc_data_q;
  logic [LANES-1:0] acc_mask_q;
  logic            done_q;
  logic            err_q;

  logic [DW-1:0]   data_ins;
  logic [LANES-1:0] mask_ins;
  logic            accept;
  logic            pack_el;
  logic            push;
  logic            stray;
  logic            done_d;
  logic            last_elem;

  logic [FW-1:0]   push_dat;
  logic [FW-1:0]   pop_dat;
  logic            pop_vld;
  logic            fifo_full;
  logic            fifo_drop;
  logic [CW-1:0]   fifo_cnt;
  logic            pop;

  assign pop       = pop_vld && wr_ready_i;
  assign last_elem = (elem_q == vlen_q - 8'd1);
  assign push_dat  = {base_q + word_q, mask_ins, data_ins};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    pack_el  = 1'b0;
    push     = 1'b0;
    stray    = 1'b0;
    done_d   = 1'b0;
    data_ins = acc_data_q;
    mask_ins = acc_mask_q;
    data_ins[lane_q*OPERAND_WIDTH +: OPERAND_WIDTH] = result_i;
    mask_ins[lane_q] = 1'b1;

    case (state_q)
      DST_IDLE: begin
        stray = done_i;
        if (start_i) begin
          accept = 1'b1;
          // Zero-length instructions complete immediately without touching the buffer.
          if (vlen_i == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = DST_COLLECT;
          end
        end
      end
      DST_COLLECT: begin
        if (done_i) begin
          pack_el = 1'b1;
          push    = last_elem || (lane_q == LW'(LANES - 1));
          if (last_elem) state_d = DST_DRAIN;
        end
      end
      DST_DRAIN: begin
        stray = done_i;
        if (pop && (fifo_cnt == CW'(1))) begin
          state_d = DST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = DST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vlen_q     <= '0;
      base_q     <= '0;
      elem_q     <= '0;
      word_q     <= '0;
      lane_q     <= '0;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        vlen_q     <= vlen_i;
        base_q     <= base_addr_i;
        elem_q     <= '0;
        word_q     <= '0;
        lane_q     <= '0;
        acc_data_q <= '0;
        acc_mask_q <= '0;
      end else if (pack_el) begin
        elem_q <= elem_q + 8'd1;
        if (push) begin
          // Next word starts empty so unfilled lanes read as zero with mask clear.
          acc_data_q <= '0;
          acc_mask_q <= '0;
          lane_q     <= '0;
          word_q     <= word_q + 8'd1;
        end else begin
          acc_data_q <= data_ins;
          acc_mask_q <= mask_ins;
          lane_q     <= lane_q + LW'(1);
        end
      end
      done_q <= done_d;
      if (accept)             err_q <= 1'b0;
      if (stray || fifo_drop) err_q <= 1'b1;
    end
  end

  vpu_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .pop_vld  (pop_vld),
    .full     (fifo_full),
    .drop     (fifo_drop),
    .count    (fifo_cnt)
  );

  // Storage is not reset, so the word fields are gated to read zero when nothing is valid.
  assign wr_valid_o = pop_vld;
  assign {wr_addr_o, wr_mask_o, wr_data_o} = pop_vld ? pop_dat : '0;
  assign busy_o = (state_q != DST_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: doc/vpu_dst_port.md
VPU_DST_PORT -- requirements
Module: vpu_dst_port

Interface
REQ-001 SHALL take parameter OPERAND_WIDTH, default 16, the bf16 element width from VPU_PKG.
REQ-002 SHALL take parameter LANES, default 4, the elements packed per write word.
REQ-003 SHALL take parameter FIFO_DEPTH, default 4, the write-word buffer entries (power of 2).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- start_i  in  1  instruction start, sampled only in IDLE.
- vlen_i  in  8  element count for the instruction, sampled with start_i.
- base_addr_i  in  8  first destination word address, sampled with start_i.
- result_i  in  OPERAND_WIDTH  FP unit result element.
- done_i  in  1  result_i valid; no backpressure to the FP unit.
- wr_valid_o  out  1  write word valid.
- wr_ready_i  in  1  register file accepts the word.
- wr_addr_o  out  8  write word address.
- wr_data_o  out  LANES*OPERAND_WIDTH  packed elements.
- wr_mask_o  out  LANES  per-lane write enable.
- busy_o  out  1  high when not IDLE.
- done_o  out  1  one-cycle pulse when the instruction completes.
- err_o  out  1  sticky error flag.

Function
REQ-006 SHALL implement states IDLE, COLLECT, DRAIN.
REQ-007 IDLE->COLLECT on start_i with vlen_i!=0; latch vlen_i and base_addr_i; clear element and word counters.
REQ-008 start_i with vlen_i==0 SHALL stay IDLE, pulse done_o the next cycle, and issue no writes.
REQ-009 start_i outside IDLE SHALL be ignored.
REQ-010 In COLLECT, element k (0-based count of done_i pulses) SHALL go to lane k%LANES, bits [16*lane+15:16*lane].
REQ-011 A word SHALL be pushed to the FIFO when lane LANES-1 fills or element vlen-1 arrives. Unfilled lanes are zero with mask bits 0.
REQ-012 COLLECT->DRAIN on the cycle the final element is packed.
REQ-013 Word n address SHALL be base_addr + n, wrapping modulo 256.
REQ-014 FIFO SHALL be first-word-fall-through: wr_valid_o rises in the cycle after the done_i cycle that completed the word.
REQ-015 A word SHALL pop only on wr_valid_o && wr_ready_i. wr_addr_o, wr_data_o and wr_mask_o SHALL stay stable while wr_valid_o && !wr_ready_i.
REQ-016 Push and pop in the same cycle SHALL be legal when full and SHALL leave the count unchanged.
REQ-017 Push when full without a pop SHALL drop the word and set err_o.
REQ-018 done_i in IDLE or DRAIN SHALL be ignored and SHALL set err_o.
REQ-019 DRAIN->IDLE when the last word is popped; done_o pulses for exactly the cycle after that pop.
REQ-020 err_o SHALL be cleared only by reset or by an accepted start_i.

Reset
REQ-021 On rst: state=IDLE, FIFO empty, counters 0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, wr_mask_o=0, busy_o=0, done_o=0, err_o=0.
REQ-022 Reset mid-operation SHALL discard all buffered words with no further write or done_o.

Structure
REQ-023 VPU_PKG SHALL hold OPERAND_WIDTH, DST_LANES, DST_FIFO_DEPTH and the dst_state_t enum.
REQ-024 The buffer SHALL be one sub-module, vpu_sync_fifo, storing {addr, mask, data}.

Verification
REQ-025 vlen=8, base=0x10, ready=1, results 0x3F80..0x3F87 back-to-back -> words at 0x10 and 0x11, mask 4'hF, lane0 of word0=0x3F80; done_o 1 cycle after the second pop.
REQ-026 vlen=5, base=0xFF -> word0 at 0xFF with mask 4'hF; word1 at 0x00 with mask 4'h1 and lanes1-3=0.
REQ-027 vlen=24, wr_ready_i=0 throughout -> 4 words buffered, 5th dropped, err_o=1; raising ready drains exactly 4 words.
REQ-028 wr_ready_i toggling every cycle while full -> simultaneous push/pop, no loss, err_o=0, addresses contiguous.
REQ-029 rst after 3 elements of vlen=8 -> all outputs 0 next cycle; no write and no done_o; a new start with vlen=0 -> done_o pulse, no write.
